// File: rtl/xbar_pkg.sv
// Shared types and constants for the crossbar slave-side arbiter.
package xbar_pkg;

  localparam int unsigned XBAR_ADDR_W = 32;
  localparam int unsigned XBAR_DATA_W = 32;
  localparam logic [31:0] XBAR_ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } xbar_state_e;

endpackage

// File: rtl/xbar_slave_arbiter_if.sv
// Master-side request/response bundle plus the downstream slave handshake.
interface xbar_slave_arbiter_if
  import xbar_pkg::*;
#(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned ADDR_W    = XBAR_ADDR_W,
  parameter int unsigned DATA_W    = XBAR_DATA_W
) ();

  logic [N_MASTERS-1:0]             m_req;
  logic [N_MASTERS-1:0][ADDR_W-1:0] m_addr;
  logic [N_MASTERS-1:0]             m_cmd;
  logic [N_MASTERS-1:0][DATA_W-1:0] m_wdata;
  logic [N_MASTERS-1:0]             m_ack;
  logic [N_MASTERS-1:0]             m_resp;
  logic [DATA_W-1:0]                m_rdata;
  logic                             m_err;

  logic                             s_req;
  logic [ADDR_W-1:0]                s_addr;
  logic                             s_cmd;
  logic [DATA_W-1:0]                s_wdata;
  logic                             s_ack;
  logic [DATA_W-1:0]                s_rdata;
  logic                             s_resp;

  // Arbiter side: consumes master requests and slave replies.
  modport slave (
    input  m_req, m_addr, m_cmd, m_wdata, s_ack, s_rdata, s_resp,
    output m_ack, m_resp, m_rdata, m_err, s_req, s_addr, s_cmd, s_wdata
  );

  // Environment side: the masters and the downstream slave.
  modport master (
    output m_req, m_addr, m_cmd, m_wdata, s_ack, s_rdata, s_resp,
    input  m_ack, m_resp, m_rdata, m_err, s_req, s_addr, s_cmd, s_wdata
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant, wrapping.
module rr_arbiter #(
  parameter int unsigned N_MASTERS = 2
) (
  input  logic [N_MASTERS-1:0]         req,
  input  logic [$clog2(N_MASTERS)-1:0] last_grant,
  output logic [N_MASTERS-1:0]         grant_c,
  output logic [$clog2(N_MASTERS)-1:0] grant_idx_c
);

  localparam int unsigned IDX_W = $clog2(N_MASTERS);

  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    cand        = '0;
    found       = 1'b0;
    grant_idx_c = '0;
    for (int unsigned i = 1; i <= N_MASTERS; i++) begin
      cand = IDX_W'((32'(last_grant) + i) % N_MASTERS);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant_idx_c = cand;
      end
    end
    grant_c = found ? (N_MASTERS'(1) << grant_idx_c) : '0;
  end

endmodule

// File: rtl/xbar_slave_arbiter.sv
// Per-slave crossbar output stage: round-robin grant, single outstanding transaction.
// Optional watchdog enabled by defining XBAR_ARB_TIMEOUT_EN.
module xbar_slave_arbiter
  import xbar_pkg::*;
#(
  parameter int unsigned N_MASTERS      = 2,
  parameter int unsigned ADDR_W         = XBAR_ADDR_W,
  parameter int unsigned DATA_W         = XBAR_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic                clk,
  input logic                reset_n,
  xbar_slave_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(N_MASTERS);

  if (N_MASTERS < 2 || N_MASTERS > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("xbar_slave_arbiter: unsupported parameter values");
  end

  xbar_state_e          state;
  logic [IDX_W-1:0]     last_grant;
  logic [IDX_W-1:0]     owner;
  logic [N_MASTERS-1:0] m_ack_q;
  logic [N_MASTERS-1:0] m_resp_q;
  logic [DATA_W-1:0]    m_rdata_q;
  logic                 m_err_q;
  logic                 s_req_q;
  logic [ADDR_W-1:0]    s_addr_q;
  logic                 s_cmd_q;
  logic [DATA_W-1:0]    s_wdata_q;

  logic [N_MASTERS-1:0] win_c;
  logic [IDX_W-1:0]     win_idx_c;
  logic [N_MASTERS-1:0] owner_oh_c;
  logic                 timeout_c;

  rr_arbiter #(.N_MASTERS(N_MASTERS)) u_rr (
    .req         (bus.m_req),
    .last_grant  (last_grant),
    .grant_c     (win_c),
    .grant_idx_c (win_idx_c)
  );

  assign owner_oh_c = N_MASTERS'(1) << owner;

`ifdef XBAR_ARB_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMR_W-1:0] tmr;

  // Cycles spent since the grant; cleared whenever the FSM is idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmr <= '0;
    end else if (state == IDLE) begin
      tmr <= '0;
    end else begin
      tmr <= tmr + TMR_W'(1);
    end
  end

  assign timeout_c = (tmr >= TMR_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_c = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= IDX_W'(N_MASTERS - 1);
      owner      <= '0;
      m_ack_q    <= '0;
      m_resp_q   <= '0;
      m_rdata_q  <= '0;
      m_err_q    <= 1'b0;
      s_req_q    <= 1'b0;
      s_addr_q   <= '0;
      s_cmd_q    <= 1'b0;
      s_wdata_q  <= '0;
    end else begin
      m_ack_q  <= '0;
      m_resp_q <= '0;
      m_err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (|bus.m_req) begin
            s_req_q    <= 1'b1;
            s_addr_q   <= bus.m_addr[win_idx_c];
            s_cmd_q    <= bus.m_cmd[win_idx_c];
            s_wdata_q  <= bus.m_wdata[win_idx_c];
            owner      <= win_idx_c;
            last_grant <= win_idx_c;
            m_ack_q    <= win_c;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.s_ack) begin
            s_req_q <= 1'b0;
            if (s_cmd_q) begin
              state <= IDLE;
            end else if (bus.s_resp) begin
              // Ack and response together: forward immediately.
              m_rdata_q <= bus.s_rdata;
              m_resp_q  <= owner_oh_c;
              state     <= IDLE;
            end else begin
              state <= WAIT_RESP;
            end
          end else if (timeout_c) begin
            s_req_q <= 1'b0;
            state   <= IDLE;
            if (!s_cmd_q) begin
              m_rdata_q <= DATA_W'(XBAR_ERR_DATA);
              m_resp_q  <= owner_oh_c;
              m_err_q   <= 1'b1;
            end
          end
        end
        WAIT_RESP: begin
          if (bus.s_resp) begin
            m_rdata_q <= bus.s_rdata;
            m_resp_q  <= owner_oh_c;
            state     <= IDLE;
          end else if (timeout_c) begin
            m_rdata_q <= DATA_W'(XBAR_ERR_DATA);
            m_resp_q  <= owner_oh_c;
            m_err_q   <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.m_ack   = m_ack_q;
  assign bus.m_resp  = m_resp_q;
  assign bus.m_rdata = m_rdata_q;
  assign bus.m_err   = m_err_q;
  assign bus.s_req   = s_req_q;
  assign bus.s_addr  = s_addr_q;
  assign bus.s_cmd   = s_cmd_q;
  assign bus.s_wdata = s_wdata_q;

endmodule

// File: tb/tb_xbar_slave_arbiter.sv
// Scoreboard bench for xbar_slave_arbiter: master agents, slave model, response monitor.
`timescale 1ns/1ps
module tb_xbar_slave_arbiter;
  import xbar_pkg::*;

  localparam int unsigned NM  = 2;
  localparam int unsigned IW  = $clog2(NM);
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 8;

  typedef struct {
    int            m;
    logic          cmd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  typedef struct {
    int            m;
    logic [DW-1:0] data;
    logic          err;
  } rsp_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   cyc     = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  txn_t cmd_q[$];
  int   exp_grant_q[$];
  txn_t exp_slv_q[$];
  rsp_t exp_rsp_q[$];

  int   ack_delay   = 0;
  bit   same_cycle  = 1'b0;
  bit   silent      = 1'b0;
  bit   hold_resp   = 1'b0;
  bit   stray_pulse = 1'b0;

  int   req_cyc  [NM];
  int   ack_cyc  [NM];
  int   resp_cyc [NM];
  int   n_resp   [NM];
  int   sresp_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  xbar_slave_arbiter_if #(.N_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW)) bus ();

  xbar_slave_arbiter #(
    .N_MASTERS      (NM),
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic issue(input int m, input logic cmd, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata);
    txn_t t;
    t.m = m; t.cmd = cmd; t.addr = addr; t.wdata = wdata;
    cmd_q.push_back(t);
  endtask

  // Expected grant, slave-side request and (for reads) response, in grant order.
  task automatic expect_txn(input int m, input logic cmd, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata);
    txn_t t;
    rsp_t r;
    t.m = m; t.cmd = cmd; t.addr = addr; t.wdata = wdata;
    exp_grant_q.push_back(m);
    exp_slv_q.push_back(t);
    if (!cmd) begin
      r.m = m; r.data = DW'(addr); r.err = 1'b0;
      exp_rsp_q.push_back(r);
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int i;
    i = 0;
    while (i < budget && !(cmd_q.size() == 0 && bus.m_req == '0 && exp_grant_q.size() == 0 &&
                           exp_slv_q.size() == 0 && exp_rsp_q.size() == 0 && bus.s_req == 1'b0)) begin
      @(negedge clk);
      i++;
    end
    check(tag, 64'(i < budget), 64'(1));
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_m_ack"},   64'(bus.m_ack),   64'(0));
    check({tag, "_m_resp"},  64'(bus.m_resp),  64'(0));
    check({tag, "_m_rdata"}, 64'(bus.m_rdata), 64'(0));
    check({tag, "_m_err"},   64'(bus.m_err),   64'(0));
    check({tag, "_s_req"},   64'(bus.s_req),   64'(0));
    check({tag, "_s_addr"},  64'(bus.s_addr),  64'(0));
    check({tag, "_s_cmd"},   64'(bus.s_cmd),   64'(0));
    check({tag, "_s_wdata"}, 64'(bus.s_wdata), 64'(0));
  endtask

  // Masters: raise a queued command, drop m_req once m_ack is seen.
  initial begin : master_agent
    bus.m_req = '0; bus.m_addr = '0; bus.m_cmd = '0; bus.m_wdata = '0;
    forever begin
      @(negedge clk);
      for (int m = 0; m < NM; m++) begin
        if (!reset_n) begin
          bus.m_req[IW'(m)] = 1'b0;
        end else if (bus.m_req[IW'(m)]) begin
          if (bus.m_ack[IW'(m)]) bus.m_req[IW'(m)] = 1'b0;
        end else begin
          for (int k = 0; k < cmd_q.size(); k++) begin
            if (cmd_q[k].m == m) begin
              bus.m_req[IW'(m)]   = 1'b1;
              bus.m_cmd[IW'(m)]   = cmd_q[k].cmd;
              bus.m_addr[IW'(m)]  = cmd_q[k].addr;
              bus.m_wdata[IW'(m)] = cmd_q[k].wdata;
              req_cyc[IW'(m)]     = cyc;
              cmd_q.delete(k);
              break;
            end
          end
        end
      end
    end
  end

  // Slave: checks the presented request, acks after ack_delay, returns rdata = addr.
  initial begin : slave_model
    txn_t          cur;
    bit            in_txn;
    bit            acked;
    bit            pending;
    int            waited;
    logic [DW-1:0] pend_data;
    in_txn = 0; acked = 0; pending = 0; waited = 0; pend_data = '0;
    cur.m = 0; cur.cmd = 1'b0; cur.addr = '0; cur.wdata = '0;
    bus.s_ack = 1'b0; bus.s_resp = 1'b0; bus.s_rdata = '0;
    forever begin
      @(negedge clk);
      bus.s_ack  = 1'b0;
      bus.s_resp = 1'b0;
      if (!reset_n) begin
        in_txn = 0; acked = 0; pending = 0;
        continue;
      end
      if (stray_pulse) begin
        bus.s_resp = 1'b1; bus.s_rdata = 32'hBAD0_0002; stray_pulse = 1'b0;
      end
      if (pending && !hold_resp) begin
        bus.s_resp = 1'b1; bus.s_rdata = pend_data; sresp_cyc = cyc; pending = 0;
      end
      if (acked) begin
        check("s_req_drop", 64'(bus.s_req), 64'(0));
        acked = 0;
      end else if (!bus.s_req) begin
        in_txn = 0;
      end else begin
        if (!in_txn) begin
          if (exp_slv_q.size() == 0) begin
            check("unexp_s_req", 64'(bus.s_req), 64'(0));
          end else begin
            cur = exp_slv_q.pop_front();
            check("s_addr",  64'(bus.s_addr),  64'(cur.addr));
            check("s_cmd",   64'(bus.s_cmd),   64'(cur.cmd));
            check("s_wdata", 64'(bus.s_wdata), 64'(cur.wdata));
          end
          in_txn = 1; waited = 0;
        end else begin
          check("s_addr_hold", 64'(bus.s_addr), 64'(cur.addr));
        end
        if (!silent && waited >= ack_delay) begin
          bus.s_ack = 1'b1; acked = 1; in_txn = 0;
          if (same_cycle) begin
            // On writes this is a stray strobe the arbiter must ignore.
            bus.s_resp  = 1'b1;
            bus.s_rdata = bus.s_cmd ? 32'hBAD0_0001 : DW'(bus.s_addr);
            sresp_cyc   = cyc;
          end else if (!bus.s_cmd) begin
            pending = 1; pend_data = DW'(bus.s_addr);
          end
        end else begin
          waited++;
        end
      end
    end
  end

  // Monitor: grant order and response routing against the scoreboard.
  initial begin : monitor
    int   idx;
    bit   found;
    rsp_t r;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (bus.m_ack != '0) begin
          check("ack_onehot", 64'($countones(bus.m_ack)), 64'(1));
          idx = 0;
          for (int m = NM - 1; m >= 0; m--) if (bus.m_ack[IW'(m)]) idx = m;
          ack_cyc[IW'(idx)] = cyc;
          if (exp_grant_q.size() == 0) check("unexp_ack", 64'(bus.m_ack), 64'(0));
          else check("grant_idx", 64'(idx), 64'(exp_grant_q.pop_front()));
        end
        if (bus.m_resp != '0) begin
          check("resp_onehot", 64'($countones(bus.m_resp)), 64'(1));
          idx = 0;
          for (int m = NM - 1; m >= 0; m--) if (bus.m_resp[IW'(m)]) idx = m;
          resp_cyc[IW'(idx)] = cyc;
          n_resp[IW'(idx)]++;
          found = 0;
          for (int k = 0; k < exp_rsp_q.size(); k++) begin
            if (!found && exp_rsp_q[k].m == idx) begin
              found = 1;
              r = exp_rsp_q[k];
              exp_rsp_q.delete(k);
            end
          end
          if (!found) begin
            check("unexp_resp", 64'(bus.m_resp), 64'(0));
          end else begin
            check("m_rdata", 64'(bus.m_rdata), 64'(r.data));
            check("m_err",   64'(bus.m_err),   64'(r.err));
            if (!r.err) check("resp_lat", 64'(cyc - sresp_cyc), 64'(1));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int before0;
    int before1;
    for (int m = 0; m < NM; m++) begin
      req_cyc[m] = 0; ack_cyc[m] = 0; resp_cyc[m] = 0; n_resp[m] = 0;
    end

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset_n = 1'b1;
    @(negedge clk);

    // Single write from master 0, slave stalls the ack.
    ack_delay = 3;
    expect_txn(0, 1'b1, 32'h10, 32'hA5A5_0001);
    issue(0, 1'b1, 32'h10, 32'hA5A5_0001);
    wait_idle("wr_done", 100);
    check("wr_ack_lat", 64'(ack_cyc[0] - req_cyc[0]), 64'(1));
    check("wr_no_resp", 64'(n_resp[0]), 64'(0));

    // Single read from master 1.
    ack_delay = 0;
    expect_txn(1, 1'b0, 32'h20, 32'h0);
    issue(1, 1'b0, 32'h20, 32'h0);
    wait_idle("rd_done", 100);
    check("rd_ack_lat", 64'(ack_cyc[1] - req_cyc[1]), 64'(1));
    check("rd_resp_m1", 64'(n_resp[1]), 64'(1));
    check("rd_resp_m0", 64'(n_resp[0]), 64'(0));

    // Both masters streaming reads: grants alternate starting at master 0.
    for (int i = 0; i < 3; i++) begin
      expect_txn(0, 1'b0, 32'h100 + 32'(i * 4), 32'h0);
      expect_txn(1, 1'b0, 32'h200 + 32'(i * 4), 32'h0);
      issue(0, 1'b0, 32'h100 + 32'(i * 4), 32'h0);
      issue(1, 1'b0, 32'h200 + 32'(i * 4), 32'h0);
    end
    wait_idle("alt_done", 300);
    check("alt_resp_m0", 64'(n_resp[0]), 64'(3));
    check("alt_resp_m1", 64'(n_resp[1]), 64'(4));

    // Ack and response in one cycle, then a write carrying a stray strobe.
    same_cycle = 1'b1;
    before0 = n_resp[0];
    expect_txn(0, 1'b0, 32'h1234, 32'h0);
    issue(0, 1'b0, 32'h1234, 32'h0);
    wait_idle("sc_rd_done", 100);
    check("sc_single_resp", 64'(n_resp[0] - before0), 64'(1));
    check("sc_resp_lat", 64'(resp_cyc[0] - ack_cyc[0]), 64'(1));
    before1 = n_resp[1];
    expect_txn(1, 1'b1, 32'h40, 32'h0BAD_F00D);
    issue(1, 1'b1, 32'h40, 32'h0BAD_F00D);
    wait_idle("sc_wr_done", 100);
    check("sc_wr_ack_lat", 64'(ack_cyc[1] - req_cyc[1]), 64'(1));
    check("sc_wr_no_resp", 64'(n_resp[1] - before1), 64'(0));
    same_cycle = 1'b0;

    // Reset while waiting for read data; the transaction is abandoned.
    hold_resp = 1'b1;
    expect_txn(0, 1'b0, 32'h300, 32'h0);
    issue(0, 1'b0, 32'h300, 32'h0);
    for (int i = 0; i < 30 && !(exp_slv_q.size() == 0 && exp_grant_q.size() == 0 &&
                                bus.s_req == 1'b0 && bus.m_req == '0); i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("wr_state_pending", 64'(exp_rsp_q.size()), 64'(1));
    reset_n = 1'b0;
    exp_rsp_q.delete();
    hold_resp = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_rst");
    @(negedge clk);
    reset_n = 1'b1;
    stray_pulse = 1'b1;
    before0 = n_resp[0];
    repeat (3) @(negedge clk);
    check("stray_ignored", 64'(n_resp[0] - before0), 64'(0));
    expect_txn(0, 1'b1, 32'h400, 32'h1);
    expect_txn(1, 1'b1, 32'h500, 32'h2);
    issue(0, 1'b1, 32'h400, 32'h1);
    issue(1, 1'b1, 32'h500, 32'h2);
    wait_idle("post_rst_done", 100);

`ifdef XBAR_ARB_TIMEOUT_EN
    // Slave never acks a read: error response after TMO cycles in flight.
    begin
      rsp_t r;
      txn_t t;
      silent = 1'b1;
      exp_grant_q.push_back(0);
      t.m = 0; t.cmd = 1'b0; t.addr = 32'h600; t.wdata = 32'h0;
      exp_slv_q.push_back(t);
      r.m = 0; r.data = XBAR_ERR_DATA; r.err = 1'b1;
      exp_rsp_q.push_back(r);
      issue(0, 1'b0, 32'h600, 32'h0);
      wait_idle("tmo_done", 100);
      check("tmo_lat", 64'(resp_cyc[0] - ack_cyc[0]), 64'(TMO));
      silent = 1'b0;
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
